// File: rtl/cpu_sys_pio_pkg.sv
// Shared constants for the cpu_sys PIO: register word addresses and parameter limits.
package cpu_sys_pio_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int MIN_SYNC  = 2;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
    localparam logic [2:0] ADDR_POL     = 3'd6;
    localparam logic [2:0] ADDR_ANYEDGE = 3'd7;

endpackage

// File: rtl/cpu_sys_pio_sync.sv
// Multi-flop synchroniser for the asynchronous pin inputs, plus the one-cycle-old
// copy of the synchronised value used for edge detection.
module cpu_sys_pio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] prev
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign prev    = prev_q;

endmodule

// File: rtl/cpu_sys_pio_gen2.sv
// Avalon-MM GPIO slave: output/direction registers, per-bit edge capture with
// selectable polarity, masked level interrupt and a registered read mux.
module cpu_sys_pio_gen2
    import cpu_sys_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [MAX_WIDTH-1:0] writedata,
    output logic [MAX_WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     out_oe,
    output logic                 irq
);

    logic [WIDTH-1:0] sync_in, prev;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] pol_q, pol_d;
    logic [WIDTH-1:0] any_q, any_d;
    logic [MAX_WIDTH-1:0] rd_q, rd_d;

    logic             wr;
    logic [WIDTH-1:0] wd, clr, rise, fall, det;
    logic             unused_wd_hi;

    assign unused_wd_hi = ^writedata;

    cpu_sys_pio_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .in_port(in_port),
        .sync_in(sync_in),
        .prev   (prev)
    );

    always_comb begin
        wr     = chipselect && !write_n;
        wd     = writedata[WIDTH-1:0];
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        pol_d  = pol_q;
        any_d  = any_q;
        clr    = '0;
        if (wr) begin
            case (address)
                ADDR_DATA:    out_d  = wd;
                ADDR_DIR:     dir_d  = wd;
                ADDR_MASK:    mask_d = wd;
                ADDR_CAPTURE: clr    = wd;
                ADDR_OUTSET:  out_d  = out_q | wd;
                ADDR_OUTCLR:  out_d  = out_q & ~wd;
                ADDR_POL:     pol_d  = wd;
                ADDR_ANYEDGE: any_d  = wd;
                default: ;
            endcase
        end

        rise = sync_in & ~prev;
        fall = ~sync_in & prev;
        det  = (any_q & (rise | fall)) | (~any_q & ((pol_q & fall) | (~pol_q & rise)));
        // OR-ing det after the clear lets a fresh edge survive a coincident W1C.
        cap_d = (cap_q & ~clr) | det;

        rd_d = '0;
        case (address)
            ADDR_DATA:    rd_d[WIDTH-1:0] = (sync_in & ~dir_q) | (out_q & dir_q);
            ADDR_DIR:     rd_d[WIDTH-1:0] = dir_q;
            ADDR_MASK:    rd_d[WIDTH-1:0] = mask_q;
            ADDR_CAPTURE: rd_d[WIDTH-1:0] = cap_q;
            ADDR_POL:     rd_d[WIDTH-1:0] = pol_q;
            ADDR_ANYEDGE: rd_d[WIDTH-1:0] = any_q;
            default:      rd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q  <= RESET_OUT;
            dir_q  <= RESET_DIR;
            mask_q <= '0;
            cap_q  <= '0;
            pol_q  <= '0;
            any_q  <= '0;
            rd_q   <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            pol_q  <= pol_d;
            any_q  <= any_d;
            rd_q   <= rd_d;
        end
    end

    assign readdata = rd_q;
    assign out_port = out_q;
    assign out_oe   = dir_q;
    assign irq      = |(cap_q & mask_q);

endmodule
